// File: rtl/pool_pkg.sv
// pool_pkg: shared pooling mode enum and width helper functions
package pool_pkg;
  typedef enum logic {POOL_MAX, POOL_AVG} pool_mode_e;
  function automatic int log2(input int v);
    int r = 0;
    for (int i = 1; i < 31; i++) if ((1 << i) <= v) r = i;
    return r;
  endfunction
  function automatic int acc_width(input int bits, input int pool, input int mode);
    return mode == int'(POOL_AVG) ? bits + 2 * log2(pool) : bits;
  endfunction
endpackage

// File: rtl/pool_lane.sv
// pool_lane: combinational load/max/sum of one lane sample against its accumulator, with average shift
module pool_lane #(
  parameter int BitSize = 8,
  parameter int AccW    = 8,
  parameter int Shift   = 0,
  parameter bit Avg     = 1'b0
) (
  input  logic [BitSize-1:0] sample,
  input  logic [AccW-1:0]    acc,
  input  logic               first,
  output logic [AccW-1:0]    nxt,
  output logic [BitSize-1:0] res
);
  logic signed [AccW-1:0] s, a, c, sh;
  assign s   = AccW'($signed(sample));
  assign a   = $signed(acc);
  assign c   = first ? s : Avg ? a + s : (s > a ? s : a);
  assign sh  = c >>> Shift;
  assign nxt = c;
  assign res = sh[BitSize-1:0];
endmodule

// File: rtl/pooling_layer_mc.sv
// pooling_layer_mc: streaming multi-channel PxP max/average pooling over time-multiplexed channel groups
module pooling_layer_mc
  import pool_pkg::*;
#(
  parameter int BitSize            = 8,
  parameter int ImageWidth         = 8,
  parameter int NumChannels        = 8,
  parameter int ProcessingElements = 2,
  parameter int PoolSize           = 2,
  parameter int Mode               = 0
) (
  input  logic                                  clk,
  input  logic                                  res_n,
  input  logic [NumChannels-1:0]                in_valid,
  input  logic [ProcessingElements*BitSize-1:0] in_data,
  output logic [NumChannels-1:0]                out_valid,
  output logic [ProcessingElements*BitSize-1:0] out_data,
  output logic                                  frame_done,
  output logic                                  err
);
  localparam int PE  = ProcessingElements;
  localparam int CPP = NumChannels / PE;
  localparam int OW  = ImageWidth / PoolSize;
  localparam int PL  = log2(PoolSize);
  localparam bit AVG = Mode == int'(POOL_AVG);
  localparam int AW  = acc_width(BitSize, PoolSize, Mode);
  localparam int GW  = CPP > 1 ? $clog2(CPP) : 1;
  localparam int XW  = $clog2(ImageWidth) + 1;
  localparam int OWW = OW > 1 ? $clog2(OW) : 1;
  localparam int CW  = NumChannels > 1 ? $clog2(NumChannels) : 1;
  logic [GW-1:0] grp;
  logic [XW-1:0] row, col;
  logic [AW-1:0] acc [OW][NumChannels];
  logic [NumChannels-1:0] mask;
  logic good, bad, in_rng, first, done, last_grp, last_col, last_row, last_win;
  logic [OWW-1:0] ocol, orow;
  logic [CW-1:0] chi [PE];
  logic [AW-1:0] cur [PE];
  logic [AW-1:0] nxt [PE];
  logic [PE*BitSize-1:0] res;
  assign mask     = NumChannels'({PE{1'b1}}) << (grp * PE);
  assign good     = in_valid == mask;
  assign bad      = |in_valid && !good;
  assign in_rng   = row < XW'(OW * PoolSize) && col < XW'(OW * PoolSize);
  assign first    = ~|row[PL-1:0] && ~|col[PL-1:0];
  assign done     = &row[PL-1:0] && &col[PL-1:0] && in_rng;
  assign ocol     = OWW'(col >> PL);
  assign orow     = OWW'(row >> PL);
  assign last_grp = grp == GW'(CPP - 1);
  assign last_col = col == XW'(ImageWidth - 1);
  assign last_row = row == XW'(ImageWidth - 1);
  assign last_win = ocol == OWW'(OW - 1) && orow == OWW'(OW - 1);
  for (genvar l = 0; l < PE; l++) begin : g_lane
    assign chi[l] = CW'(grp * PE + l);
    assign cur[l] = acc[ocol][chi[l]];
    pool_lane #(
      .BitSize(BitSize),
      .AccW   (AW),
      .Shift  (AVG ? 2 * PL : 0),
      .Avg    (AVG)
    ) u_lane (
      .sample(in_data[l*BitSize +: BitSize]),
      .acc   (cur[l]),
      .first (first),
      .nxt   (nxt[l]),
      .res   (res[l*BitSize +: BitSize])
    );
  end
  always_ff @(posedge clk) begin
    if (res_n) begin
      grp        <= '0;
      row        <= '0;
      col        <= '0;
      out_valid  <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < OW; i++)
        for (int j = 0; j < NumChannels; j++) acc[i][j] <= '0;
    end else begin
      out_valid  <= '0;
      frame_done <= 1'b0;
      if (bad) err <= 1'b1;
      if (good) begin
        if (in_rng) for (int i = 0; i < PE; i++) acc[ocol][chi[i]] <= nxt[i];
        if (done) begin
          out_valid  <= in_valid;
          out_data   <= res;
          frame_done <= last_win && last_grp;
        end
        if (last_grp) begin
          grp <= '0;
          col <= last_col ? '0 : col + 1'b1;
          if (last_col) row <= last_row ? '0 : row + 1'b1;
        end else begin
          grp <= grp + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pooling_layer_mc.sv
// tb_pooling_layer_mc: table-driven check of max and average pooling instances on a 4x4x4 stream
module tb_pooling_layer_mc;
  logic clk = 1'b0;
  logic res_n;
  logic [3:0] in_valid;
  logic [15:0] in_data;
  logic [3:0] ov_m, ov_a;
  logic [15:0] od_m, od_a;
  logic fd_m, fd_a, er_m, er_a;
  typedef struct {
    logic [3:0] mask;
    logic [7:0] mx0, mx1, av0, av1;
    logic       fd;
  } exp_t;
  exp_t tbl [8];
  exp_t save;
  logic [7:0] ch0 [16];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  pooling_layer_mc #(
    .BitSize(8), .ImageWidth(4), .NumChannels(4), .ProcessingElements(2), .PoolSize(2), .Mode(0)
  ) u_max (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_m), .out_data(od_m), .frame_done(fd_m), .err(er_m)
  );
  pooling_layer_mc #(
    .BitSize(8), .ImageWidth(4), .NumChannels(4), .ProcessingElements(2), .PoolSize(2), .Mode(1)
  ) u_avg (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_a), .out_data(od_a), .frame_done(fd_a), .err(er_a)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask
  task automatic out_chk(input bit v, input int k);
    chk("max_valid", 32'(ov_m), v ? 32'(tbl[k].mask) : 32'd0);
    chk("avg_valid", 32'(ov_a), v ? 32'(tbl[k].mask) : 32'd0);
    chk("max_done", 32'(fd_m), v ? 32'(tbl[k].fd) : 32'd0);
    chk("avg_done", 32'(fd_a), v ? 32'(tbl[k].fd) : 32'd0);
    if (v) begin
      chk("max_data", 32'(od_m), 32'({tbl[k].mx1, tbl[k].mx0}));
      chk("avg_data", 32'(od_a), 32'({tbl[k].av1, tbl[k].av0}));
    end
  endtask
  task automatic send(input logic [3:0] m, input logic [15:0] d, input bit v, input int k);
    in_valid = m;
    in_data  = d;
    @(negedge clk);
    out_chk(v, k);
  endtask
  task automatic idle();
    in_valid = 4'b0000;
    in_data  = 16'($urandom);
    @(negedge clk);
    out_chk(1'b0, 0);
  endtask
  task automatic frame(input int npix, input bit gaps);
    for (int p = 0; p < npix; p++) begin
      int r, c, w;
      bit v;
      r = p / 4;
      c = p % 4;
      v = (r % 2 == 1) && (c % 2 == 1);
      w = (r / 2) * 2 + c / 2;
      send(4'b0011, {8'(16 - p), ch0[p]}, v, w * 2);
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      send(4'b1100, {8'h00, 8'(-(p + 1))}, v, w * 2 + 1);
      if (gaps) repeat ($urandom_range(0, 2)) idle();
    end
  endtask
  task automatic chk_err(input logic e);
    chk("max_err", 32'(er_m), 32'(e));
    chk("avg_err", 32'(er_a), 32'(e));
  endtask
  initial begin
    for (int p = 0; p < 16; p++) ch0[p] = 8'(p + 1);
    tbl[0] = '{4'b0011, 8'd6,  8'd16, 8'd3,  8'd13, 1'b0};
    tbl[1] = '{4'b1100, 8'hFF, 8'h00, 8'hFC, 8'h00, 1'b0};
    tbl[2] = '{4'b0011, 8'd8,  8'd14, 8'd5,  8'd11, 1'b0};
    tbl[3] = '{4'b1100, 8'hFD, 8'h00, 8'hFA, 8'h00, 1'b0};
    tbl[4] = '{4'b0011, 8'd14, 8'd8,  8'd11, 8'd5,  1'b0};
    tbl[5] = '{4'b1100, 8'hF7, 8'h00, 8'hF4, 8'h00, 1'b0};
    tbl[6] = '{4'b0011, 8'd16, 8'd6,  8'd13, 8'd3,  1'b0};
    tbl[7] = '{4'b1100, 8'hF5, 8'h00, 8'hF2, 8'h00, 1'b1};
    res_n    = 1'b1;
    in_valid = 4'b0000;
    in_data  = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_max_valid", 32'(ov_m), 32'd0);
    chk("rst_avg_valid", 32'(ov_a), 32'd0);
    chk("rst_max_data", 32'(od_m), 32'd0);
    chk("rst_avg_data", 32'(od_a), 32'd0);
    chk("rst_max_done", 32'(fd_m), 32'd0);
    chk("rst_avg_done", 32'(fd_a), 32'd0);
    chk_err(1'b0);
    res_n = 1'b0;
    frame(16, 1'b0);
    chk_err(1'b0);
    frame(16, 1'b1);
    chk_err(1'b0);
    save = tbl[0];
    ch0[0] = 8'h80;
    ch0[1] = 8'hFF;
    ch0[4] = 8'hFE;
    ch0[5] = 8'hFD;
    tbl[0].mx0 = 8'hFF;
    tbl[0].av0 = 8'hDE;
    frame(16, 1'b0);
    tbl[0] = save;
    for (int p = 0; p < 16; p++) ch0[p] = 8'(p + 1);
    frame(5, 1'b0);
    res_n    = 1'b1;
    in_valid = 4'b0011;
    in_data  = 16'h1234;
    @(negedge clk);
    chk("rst_mid_max_valid", 32'(ov_m), 32'd0);
    chk("rst_mid_avg_valid", 32'(ov_a), 32'd0);
    res_n = 1'b0;
    frame(16, 1'b0);
    chk_err(1'b0);
    send(4'b0101, 16'h7F7F, 1'b0, 0);
    chk_err(1'b1);
    frame(16, 1'b0);
    chk_err(1'b1);
    send(4'b1100, 16'h7F7F, 1'b0, 0);
    frame(16, 1'b0);
    chk_err(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
